fetch_inst_queue: RTL and testbench
===================================

Name: fetch_inst_queue

Overview:
- Instruction queue between the fetch stage (next-PC generator plus I-cache) and the dual-issue decoder.
- Accepts 8-byte-aligned fetch packets of two instruction slots; slot 0 is skipped when the fetch-start bit (fsc) is 1.
- Stores individual instructions in a circular FIFO and presents the oldest two to decode in program order.
- Back-pressures fetch through ready_o; the fetch stage converts !ready_o into its stall.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush_i  in  1  redirect; discard all contents
- in_valid_i  in  1  fetch packet present this cycle
- in_pc_i  in  32  packet PC; bits [2:0] ignored, packet base = {in_pc_i[31:3],3'b000}
- in_fsc_i  in  1  1: only slot 1 valid; 0: both slots valid
- in_inst_i  in  64  [31:0] slot 0, [63:32] slot 1
- ready_o  out  1  queue can accept a full packet this cycle
- out_valid_o  out  2  bit0: entry 0 valid; bit1: entry 1 valid
- out0_pc_o  out  32  PC of oldest entry
- out0_inst_o  out  32  instruction of oldest entry
- out1_pc_o  out  32  PC of second-oldest entry
- out1_inst_o  out  32  instruction of second-oldest entry
- deq_cnt_i  in  2  entries consumed by decode this cycle; 0, 1 or 2

Behaviour:

Storage:
- DEPTH entries of {pc[31:0], inst[31:0]}.
- head and tail pointers, PTR_W bits, wrap modulo DEPTH.
- count register, PTR_W+1 bits, range 0..DEPTH.

Reset (asynchronous, rst=1):
- head=0, tail=0, count=0.
- out_valid_o=2'b00, ready_o=1.
- Entry contents are don't-care, but out*_pc_o and out*_inst_o must be driven with no X propagation (drive 0 when invalid).
- Reset asserted mid-operation drops all contents immediately.

ready_o:
- Combinational: ready_o = (count <= DEPTH-2), computed from the current count only.
- It does not account for a same-cycle dequeue. This is deliberate, to keep it off the decode timing path.

Enqueue (accept = in_valid_i & ready_o & !flush_i):
- fsc=0: write slot 0 at tail with pc=base, then slot 1 at tail+1 with pc=base+4; tail += 2.
- fsc=1: write slot 1 at tail with pc=base+4; tail += 1.
- in_valid_i while ready_o=0: the packet is ignored. Fetch must hold the packet or re-present it.

Dequeue:
- out entry 0 = mem[head]; out entry 1 = mem[head+1] (wrapping).
- Outputs are combinational from the registers; new enqueues are visible on the cycle after the write.
- out_valid_o = {count>=2, count>=1}.
- head += deq_cnt_i; count updates as count + enq_n - deq_cnt_i in the same cycle.
- deq_cnt_i greater than the number of valid entries is illegal. It must be caught by an assertion; the RTL clamps deq_cnt_i to the valid count.
- deq_cnt_i=3 is illegal and is treated as 2.

Flush:
- flush_i=1 sets head=0, tail=0, count=0 on the next edge.
- Same-cycle enqueue and dequeue are discarded.
- flush_i has priority over everything except rst.
- The cycle after a flush: out_valid_o=00, ready_o=1.

Boundaries:
- Pointer wrap: entries straddling DEPTH-1 to 0 are read correctly as out0/out1.
- Full queue (count=DEPTH): ready_o=0 and out_valid_o=11.
- Simultaneous enqueue of 2 and dequeue of 2 at count=DEPTH-2: count is unchanged.

Latency:
- Packet accepted at edge N → out_valid_o reflects it after edge N, i.e. 1 cycle in the queue minimum.
- No bypass path.

Test Plan:
1. Reset then in_pc=0x1c000000, fsc=0, inst={0xB,0xA}, deq=0 → next cycle out_valid=11, out0={0x1c000000,0xA}, out1={0x1c000004,0xB}.
2. in_pc=0x1c000004, fsc=1, inst[63:32]=0xC → single entry {0x1c000004,0xC}, out_valid=01, count=1.
3. Enqueue 2 per cycle with deq=0 from empty, DEPTH=8 → ready_o=1 at count 0,2,4,6 and 0 at count 8; a 5th packet presented while ready_o=0 is dropped with tail unchanged; then deq=1 → count 7, ready_o stays 0; a further deq=1 → count 6, ready_o=1.
4. Steady stream (enqueue 2, deq 2 every cycle) through 3 pointer wraps → PCs strictly sequential +4, no loss or duplication, out1 correct when head=7.
5. Queue holding 5 entries, flush_i=1 with in_valid=1 and deq=2 the same cycle → next cycle out_valid=00, count=0; the next packet lands at entry 0.
6. rst pulsed asynchronously between clock edges while 6 entries are held → out_valid_o=00 and ready_o=1 without a clock edge; normal enqueue resumes after rst deasserts.

Source files
------------

// File: rtl/fetch_inst_queue.sv
`default_nettype none
// ============================================================================
// fetch_inst_queue : circular instruction FIFO between fetch and dual decode
// Revision: 1.0
// ============================================================================
module fetch_inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_pc_i,
  input  logic        in_fsc_i,
  input  logic [63:0] in_inst_i,
  output logic        ready_o,
  output logic [1:0]  out_valid_o,
  output logic [31:0] out0_pc_o,
  output logic [31:0] out0_inst_o,
  output logic [31:0] out1_pc_o,
  output logic [31:0] out1_inst_o,
  input  logic [1:0]  deq_cnt_i
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_inst_q [DEPTH];

  logic [31:0]      w_base_pc;
  logic             w_accept;
  logic [1:0]       w_enq_n;
  logic [1:0]       w_deq_req;
  logic [1:0]       w_deq_avail;
  logic [1:0]       w_deq_eff;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;

  // ready looks only at the registered count to stay off the decode path
  assign ready_o     = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign out_valid_o = {(count_q >= (PTR_W+1)'(2)), (count_q != '0)};

  always_comb begin
    w_base_pc   = {in_pc_i[31:3], 3'b000};
    w_accept    = in_valid_i & ready_o & ~flush_i;
    w_enq_n     = w_accept ? (in_fsc_i ? 2'd1 : 2'd2) : 2'd0;
    w_deq_req   = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
    w_deq_avail = (count_q >= (PTR_W+1)'(2)) ? 2'd2 : count_q[1:0];
    w_deq_eff   = (w_deq_req > w_deq_avail) ? w_deq_avail : w_deq_req;
    w_head_p1   = head_q + PTR_W'(1);
    w_tail_p1   = tail_q + PTR_W'(1);

    head_d  = head_q + PTR_W'(w_deq_eff);
    tail_d  = tail_q + PTR_W'(w_enq_n);
    count_d = count_q + (PTR_W+1)'(w_enq_n) - (PTR_W+1)'(w_deq_eff);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; outputs are masked by the valid count instead
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (in_fsc_i) begin
        mem_pc_q[tail_q]   <= w_base_pc + 32'd4;
        mem_inst_q[tail_q] <= in_inst_i[63:32];
      end else begin
        mem_pc_q[tail_q]      <= w_base_pc;
        mem_inst_q[tail_q]    <= in_inst_i[31:0];
        mem_pc_q[w_tail_p1]   <= w_base_pc + 32'd4;
        mem_inst_q[w_tail_p1] <= in_inst_i[63:32];
      end
    end
  end

  always_comb begin
    out0_pc_o   = out_valid_o[0] ? mem_pc_q[head_q]      : 32'd0;
    out0_inst_o = out_valid_o[0] ? mem_inst_q[head_q]    : 32'd0;
    out1_pc_o   = out_valid_o[1] ? mem_pc_q[w_head_p1]   : 32'd0;
    out1_inst_o = out_valid_o[1] ? mem_inst_q[w_head_p1] : 32'd0;
  end

  a_deq_within_count: assert property (
    @(posedge clk) disable iff (rst) !flush_i |-> (w_deq_req <= w_deq_avail)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_inst_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_inst_queue : directed vector bench for fetch_inst_queue
// Revision: 1.0
// ============================================================================
module tb_fetch_inst_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_pc_i;
  logic        in_fsc_i;
  logic [63:0] in_inst_i;
  logic        ready_o;
  logic [1:0]  out_valid_o;
  logic [31:0] out0_pc_o;
  logic [31:0] out0_inst_o;
  logic [31:0] out1_pc_o;
  logic [31:0] out1_inst_o;
  logic [1:0]  deq_cnt_i;

  int n_checks = 0;
  int n_errors = 0;

  fetch_inst_queue #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_pc_i     (in_pc_i),
    .in_fsc_i    (in_fsc_i),
    .in_inst_i   (in_inst_i),
    .ready_o     (ready_o),
    .out_valid_o (out_valid_o),
    .out0_pc_o   (out0_pc_o),
    .out0_inst_o (out0_inst_o),
    .out1_pc_o   (out1_pc_o),
    .out1_inst_o (out1_inst_o),
    .deq_cnt_i   (deq_cnt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        vld;
    logic [31:0] pc;
    logic        fsc;
    logic [63:0] inst;
    logic [1:0]  deq;
    logic        e_rdy;
    logic [1:0]  e_val;
    logic [31:0] e0p;
    logic [31:0] e0i;
    logic [31:0] e1p;
    logic [31:0] e1i;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic [1:0] val,
                          input logic [31:0] p0, input logic [31:0] i0,
                          input logic [31:0] p1, input logic [31:0] i1);
    chk({tag, " ready"}, {31'd0, ready_o}, {31'd0, rdy});
    chk({tag, " valid"}, {30'd0, out_valid_o}, {30'd0, val});
    chk({tag, " out0_pc"}, out0_pc_o, p0);
    chk({tag, " out0_inst"}, out0_inst_o, i0);
    chk({tag, " out1_pc"}, out1_pc_o, p1);
    chk({tag, " out1_inst"}, out1_inst_o, i1);
  endtask

  // Drive one cycle of inputs, let the edge happen, return on the next negedge
  task automatic apply(input logic fl, input logic vld, input logic [31:0] pc,
                       input logic fsc, input logic [63:0] inst, input logic [1:0] deq);
    flush_i    = fl;
    in_valid_i = vld;
    in_pc_i    = pc;
    in_fsc_i   = fsc;
    in_inst_i  = inst;
    deq_cnt_i  = deq;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return ~pc;
  endfunction

  function automatic logic [63:0] pkt(input logic [31:0] base);
    return {ins(base + 32'd4), ins(base)};
  endfunction

  initial begin
    logic [31:0] e;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_pc_i = '0;
    in_fsc_i = 1'b0; in_inst_i = '0; deq_cnt_i = '0;

    tbl[0] = '{1'b0, 1'b1, 32'h1c000000, 1'b0, {32'hB, 32'hA}, 2'd0,
               1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2,
               1'b1, 2'b11, 32'h1c000000, 32'hA, 32'h1c000004, 32'hB};
    tbl[2] = '{1'b0, 1'b1, 32'h1c000006, 1'b1, {32'hC, 32'hDEAD}, 2'd0,
               1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd1,
               1'b1, 2'b01, 32'h1c000004, 32'hC, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h2000, 1'b0, {32'h22, 32'h21}, 2'd0,
               1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 32'h2008, 1'b0, {32'h24, 32'h23}, 2'd3,
               1'b1, 2'b11, 32'h2000, 32'h21, 32'h2004, 32'h22};
    tbl[6] = '{1'b0, 1'b1, 32'h2010, 1'b1, {32'h25, 32'hFF}, 2'd1,
               1'b1, 2'b11, 32'h2008, 32'h23, 32'h200c, 32'h24};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2,
               1'b1, 2'b11, 32'h200c, 32'h24, 32'h2014, 32'h25};
    tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0,
               1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      chk_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_val,
               tbl[i].e0p, tbl[i].e0i, tbl[i].e1p, tbl[i].e1i);
      apply(tbl[i].flush, tbl[i].vld, tbl[i].pc, tbl[i].fsc, tbl[i].inst, tbl[i].deq);
    end

    // Fill to full, drop a packet while not ready, then drain in order
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d ready", k), {31'd0, ready_o}, 32'd1);
      apply(1'b0, 1'b1, 32'h3000 + 32'(8 * k), 1'b0, pkt(32'h3000 + 32'(8 * k)), 2'd0);
    end
    chk_outs("full", 1'b0, 2'b11, 32'h3000, ins(32'h3000), 32'h3004, ins(32'h3004));
    apply(1'b0, 1'b1, 32'h3020, 1'b0, pkt(32'h3020), 2'd0);
    chk_outs("drop", 1'b0, 2'b11, 32'h3000, ins(32'h3000), 32'h3004, ins(32'h3004));
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd1);
    chk_outs("cnt7", 1'b0, 2'b11, 32'h3004, ins(32'h3004), 32'h3008, ins(32'h3008));
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd1);
    chk_outs("cnt6", 1'b1, 2'b11, 32'h3008, ins(32'h3008), 32'h300c, ins(32'h300c));
    for (int k = 0; k < 3; k++) begin
      e = 32'h3008 + 32'(8 * k);
      chk($sformatf("drain%0d out0", k), out0_pc_o, e);
      chk($sformatf("drain%0d out1", k), out1_pc_o, e + 32'd4);
      apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2);
    end
    chk("drained valid", {30'd0, out_valid_o}, 32'd0);

    // Odd-aligned steady stream so head visits 7 on every wrap
    apply(1'b0, 1'b1, 32'h4000, 1'b1, pkt(32'h4000), 2'd0);
    chk_outs("strm prime", 1'b1, 2'b01, 32'h4004, ins(32'h4004), 32'h0, 32'h0);
    apply(1'b0, 1'b1, 32'h4008, 1'b0, pkt(32'h4008), 2'd1);
    for (int j = 0; j < 12; j++) begin
      e = 32'h4008 + 32'(8 * j);
      chk_outs($sformatf("strm%0d", j), 1'b1, 2'b11, e, ins(e), e + 32'd4, ins(e + 32'd4));
      apply(1'b0, 1'b1, 32'h4010 + 32'(8 * j), 1'b0, pkt(32'h4010 + 32'(8 * j)), 2'd2);
    end
    chk_outs("strm last", 1'b1, 2'b11, 32'h4068, ins(32'h4068), 32'h406c, ins(32'h406c));
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2);
    chk("strm empty", {30'd0, out_valid_o}, 32'd0);

    // Flush beats a same-cycle enqueue and dequeue
    apply(1'b0, 1'b1, 32'h5000, 1'b0, pkt(32'h5000), 2'd0);
    apply(1'b0, 1'b1, 32'h5008, 1'b0, pkt(32'h5008), 2'd0);
    apply(1'b0, 1'b1, 32'h5010, 1'b1, pkt(32'h5010), 2'd0);
    chk_outs("pre flush", 1'b1, 2'b11, 32'h5000, ins(32'h5000), 32'h5004, ins(32'h5004));
    apply(1'b1, 1'b1, 32'h5018, 1'b0, pkt(32'h5018), 2'd2);
    chk_outs("post flush", 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    apply(1'b0, 1'b1, 32'h6000, 1'b0, pkt(32'h6000), 2'd0);
    chk_outs("after flush", 1'b1, 2'b11, 32'h6000, ins(32'h6000), 32'h6004, ins(32'h6004));
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2);

    // Asynchronous reset between edges while holding 6 entries
    apply(1'b0, 1'b1, 32'h7000, 1'b0, pkt(32'h7000), 2'd0);
    apply(1'b0, 1'b1, 32'h7008, 1'b0, pkt(32'h7008), 2'd0);
    apply(1'b0, 1'b1, 32'h7010, 1'b0, pkt(32'h7010), 2'd0);
    in_valid_i = 1'b0;
    chk_outs("six held", 1'b1, 2'b11, 32'h7000, ins(32'h7000), 32'h7004, ins(32'h7004));
    #2 rst = 1'b1;
    #1 chk_outs("async rst", 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst held valid", {30'd0, out_valid_o}, 32'd0);
    apply(1'b0, 1'b1, 32'h7100, 1'b0, pkt(32'h7100), 2'd0);
    chk_outs("post rst", 1'b1, 2'b11, 32'h7100, ins(32'h7100), 32'h7104, ins(32'h7104));
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd2);
    chk("final empty", {30'd0, out_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
